// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: state encoding and default parameters shared by the input conditioner.
package input_conditioner_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_WAIT_HIGH,
        ST_HIGH,
        ST_WAIT_LOW
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ff_q <= '0;
        else        ff_q <= {ff_q[STAGES-2:0], d};
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces a raw level, with edge pulses and a qualification flag.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d, fall_q, fall_d;
    logic          s;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (din),
        .q    (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A return of s to the current level wins over a commit in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_LOW: if (s) begin
                state_d = ST_WAIT_HIGH;
                cnt_d   = '0;
            end
            ST_HIGH: if (!s) begin
                state_d = ST_WAIT_LOW;
                cnt_d   = '0;
            end
            ST_WAIT_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (en) begin
                    state_d = (cnt_q == CNT_MAX) ? ST_HIGH : ST_WAIT_HIGH;
                    cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
                    rise_d  = (cnt_q == CNT_MAX);
                end
            end
            ST_WAIT_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (en) begin
                    state_d = (cnt_q == CNT_MAX) ? ST_LOW : ST_WAIT_LOW;
                    cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
                    fall_d  = (cnt_q == CNT_MAX);
                end
            end
        endcase
    end

    assign q    = (state_q == ST_HIGH) || (state_q == ST_WAIT_LOW);
    assign busy = (state_q == ST_WAIT_HIGH) || (state_q == ST_WAIT_LOW);
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios with a queue of expected {q,rise,fall,busy} per edge.
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset, din, en;
    logic q, rise, fall, busy;
    logic [3:0] sb[$];
    logic prev_rise = 1'b0, prev_fall = 1'b0;
    int checks = 0, errors = 0;

    input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .en   (en),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag);
        logic [3:0] exp, obs;
        exp = sb.pop_front();
        obs = {q, rise, fall, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s {q,rise,fall,busy} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic e, input logic [3:0] exp, input string tag);
        din = d;
        en  = e;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // Clean qualification from a settled opposite level: waiting from edge 3, commit at edge `commit`.
    task automatic qualify(input logic d, input bit gated, input int commit, input int n, input string tag);
        for (int k = 1; k <= n; k++)
            step(d, gated ? (k % 2 == 0) : 1'b1,
                 {(k >= commit) ? d : ~d, d && k == commit, !d && k == commit, k >= 3 && k < commit}, tag);
    endtask

    always @(negedge clk) begin
        checks++;
        assert (!(rise && fall)) else begin
            errors++;
            $error("FAIL rise_and_fall observed=%b%b expected=not both", rise, fall);
        end
        checks++;
        assert (dut.cnt_q <= 3) else begin
            errors++;
            $error("FAIL cnt_bound observed=%0d expected<=3", dut.cnt_q);
        end
        checks++;
        assert (!(rise && prev_rise) && !(fall && prev_fall)) else begin
            errors++;
            $error("FAIL pulse_width observed=rise%b%b fall%b%b expected=single cycle",
                   prev_rise, rise, prev_fall, fall);
        end
        prev_rise = rise;
        prev_fall = fall;
    end

    initial begin
        reset = 1'b0;
        din   = 1'b1;
        en    = 1'b1;
        #1;
        sb.push_back(4'b0000);
        compare("reset_now");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 4'b0000, "reset_hold");
        reset = 1'b1;
        qualify(1'b1, 1'b0, 7, 10, "reset_release_rise");
        qualify(1'b0, 1'b0, 7, 10, "clean_fall");
        qualify(1'b1, 1'b0, 7, 10, "clean_rise");
        qualify(1'b0, 1'b0, 7, 10, "clean_fall2");
        for (int k = 1; k <= 10; k++) step(k <= 3, 1'b1, {3'b000, k >= 3 && k <= 5}, "glitch");
        qualify(1'b1, 1'b1, 10, 12, "en_gated_rise");
        qualify(1'b0, 1'b0, 7, 10, "fall_after_gated");
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, {3'b000, k >= 3}, "midwait_pre");
        reset = 1'b0;
        #1;
        sb.push_back(4'b0000);
        compare("midwait_reset_now");
        for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 4'b0000, "midwait_in_reset");
        reset = 1'b1;
        qualify(1'b1, 1'b0, 7, 10, "midwait_release_rise");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on din (legal range 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, enabled cycles din must stay stable before q follows (legal range 2..65535).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-005 Port din  input  1  raw asynchronous level (switch/button); feeds the D/en inputs of downstream flip-flop stages once conditioned.
REQ-006 Port en  input  1  count-enable tick; debounce counter advances only on cycles with en=1.
REQ-007 Port q  output  1  debounced, synchronized level of din.
REQ-008 Port rise  output  1  one-cycle pulse on the cycle q goes 0->1.
REQ-009 Port fall  output  1  one-cycle pulse on the cycle q goes 1->0.
REQ-010 Port busy  output  1  high while a candidate transition is being qualified (WAIT states).

Function
REQ-011 din SHALL pass through SYNC_STAGES flops clocked every clk regardless of en; last stage is s.
REQ-012 FSM states SHALL be ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW; q=1 only in ST_HIGH and ST_WAIT_LOW.
REQ-013 ST_LOW: s=1 -> ST_WAIT_HIGH, counter cleared to 0; else stay.
REQ-014 ST_HIGH: s=0 -> ST_WAIT_LOW, counter cleared to 0; else stay.
REQ-015 WAIT state, s still differs from q, en=1: counter increments by 1.
REQ-016 WAIT state, en=1 and counter==DEBOUNCE_CYCLES-1 and s differs from q: commit to opposite stable state; q toggles on that edge.
REQ-017 WAIT state, s equals q (glitch): return to originating stable state, counter cleared, no pulse; this check takes priority over REQ-016.
REQ-018 WAIT state, en=0: counter holds, state holds unless REQ-017 applies.
REQ-019 rise/fall SHALL be registered, high exactly the one cycle after q changes; never both high; never high outside a commit.
REQ-020 Latency with en tied high: q changes on rising edge SYNC_STAGES+DEBOUNCE_CYCLES+1 after din settles before an edge.
REQ-021 Counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits minimum; counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
REQ-022 busy SHALL equal 1 exactly in ST_WAIT_HIGH and ST_WAIT_LOW.

Reset
REQ-023 reset=0 SHALL immediately force synchronizer flops to 0, state to ST_LOW, counter to 0, q=0, rise=0, fall=0, busy=0.
REQ-024 Reset asserted mid-qualification SHALL abandon the candidate; no pulse is emitted on or after reset release.
REQ-025 After reset release with din=1, a normal rise SHALL occur per REQ-020.

Structure
REQ-026 Package input_conditioner_pkg SHALL hold the state enum typedef (state_t) and the default parameter constants.
REQ-027 Synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, reset, d, q); FSM/counter stay in input_conditioner.

Verification (bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clk)
REQ-028 Reset: reset=0 with din=1, en=1 -> q=0, rise=0, fall=0, busy=0 throughout; release -> rise pulses on edge 7 after release, q=1 thereafter.
REQ-029 Clean rise then fall: din 0->1, hold 10 cycles, en=1 -> q=1 on edge 7, rise high one cycle; din 1->0 -> q=0 on edge 7, fall one cycle.
REQ-030 Glitch reject: din=1 for 3 cycles then 0, en=1 -> busy pulses, q stays 0, rise never asserts.
REQ-031 Enable gating: din 0->1, en high every other cycle -> q=1 only after 4 enabled counts in WAIT_HIGH (edge 10), single rise pulse.
REQ-032 Reset mid-wait: din 0->1, reset=0 at edge 5 for 2 cycles, din held 1 -> no pulse during reset; after release rise on edge 7.
REQ-033 Assertions: rise&&fall never; counter<=3 always; rise/fall only one cycle wide.
